audio_i2s_tx: RTL and testbench
===============================

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 Parameter SCLK_HALF, default 8, CLK cycles per SCLK half-period (legal range 2..255).
REQ-002 Parameter MCLK_HALF, default 2, CLK cycles per MCLK half-period (legal range 1..255).
REQ-003 Parameter UNSIGNED_IN, default 1; 1 means inputs are offset-binary and are converted to two's complement before transmit.
REQ-004 CLK  input  1  system clock, 50 MHz nominal; every register is clocked on its rising edge.
REQ-005 I_RESET_N  input  1  asynchronous, active-low reset.
REQ-006 I_L_DATA  input  16  left sample from the game core DAC output, sampled continuously.
REQ-007 I_R_DATA  input  16  right sample, same rules as I_L_DATA.
REQ-008 O_MCLK  output  1  codec master clock.
REQ-009 O_SCLK  output  1  I2S bit clock.
REQ-010 O_LRCK  output  1  word select; 0 = left slot, 1 = right slot.
REQ-011 O_SDIN  output  1  serial data to the codec.
REQ-012 O_SAMPLE_REQ  output  1  one-CLK pulse at the instant both input samples are captured.

Function
REQ-013 Half-period counter hc runs 0..SCLK_HALF-1; when it wraps, O_SCLK toggles.
REQ-014 A 6-bit bit counter bc increments modulo 64 on every SCLK falling edge only (O_SCLK 1->0).
REQ-015 On each SCLK falling edge, O_LRCK takes bc_new[5], where bc_new is the post-increment value.
REQ-016 Slot position p = bc_new[4:0].
REQ-017 For p = 1..16, O_SDIN = holding bit (16-p) for the current channel, MSB first.
REQ-018 For p = 0 and p = 17..31, O_SDIN = 0. This gives standard I2S: the MSB is sent one SCLK after the LRCK edge, in 32-bit slots.
REQ-019 O_SDIN and O_LRCK change only on SCLK falling edges; they are stable across each rising edge.
REQ-020 When bc_new = 0, the block captures I_L_DATA and I_R_DATA into holding registers HL/HR in the same CLK cycle.
REQ-021 O_SAMPLE_REQ is high for exactly that one CLK cycle.
REQ-022 With UNSIGNED_IN=1, the captured value has bit 15 inverted.
REQ-023 With UNSIGNED_IN=0, the captured value is taken unchanged.
REQ-024 Input changes outside the capture cycle do not affect the frame in progress, including a change mid-slot.
REQ-025 Counter mc runs 0..MCLK_HALF-1; O_MCLK toggles on each wrap.
REQ-026 O_MCLK is free-running, independent of SCLK, and phase-aligned to reset release.
REQ-027 Defaults give: SCLK 3.125 MHz, LRCK 48.83 kHz (1024 CLK per frame), MCLK 12.5 MHz = 256 x LRCK.
REQ-028 All outputs are registered; there are no combinational paths from any input to any output.

Reset
REQ-029 While I_RESET_N = 0, outputs are: O_MCLK=0, O_SCLK=0, O_LRCK=0, O_SDIN=0, O_SAMPLE_REQ=0.
REQ-030 While I_RESET_N = 0, internal state is: hc=0, mc=0, bc=63, HL=0, HR=0.
REQ-031 Reset assertion takes effect immediately (asynchronously); deassertion is synchronised by a 2-flop chain inside the block.
REQ-032 After the synchronised release, the first SCLK rising edge occurs after SCLK_HALF CLK cycles.
REQ-033 The first falling edge occurs after 2*SCLK_HALF CLK cycles; at that edge bc wraps to 0 and the first capture occurs.
REQ-034 Reset asserted mid-frame aborts the frame immediately: no partial word is completed, and the next frame restarts per REQ-032/033.

Verification
REQ-035 Reset check: hold I_RESET_N=0 for 10 CLK -> all five outputs are 0. Release -> O_SAMPLE_REQ pulses exactly once, at release + 2 sync cycles + 16 CLK.
REQ-036 Serial data check: UNSIGNED_IN=0, L=16'hA5C3, R=16'h3C5A.
  - Bits sampled on SCLK rising edges in the left slot, p=1..16 -> A5C3 MSB first; p=17..31 and p=0 -> 0.
  - The right slot carries 3C5A in the same layout.
REQ-037 Offset-binary check: UNSIGNED_IN=1, L=16'h8000, R=16'hFFFF -> left word transmitted 16'h0000, right word 16'h7FFF.
REQ-038 Mid-frame input change: change L from 16'h1234 to 16'hFFFF at bit position p=5 of the left slot.
  - The current frame completes with 1234.
  - The next frame carries FFFF.
  - O_SAMPLE_REQ pulses are exactly 1024 CLK apart.
REQ-039 Clock ratio check at default parameters: O_MCLK period = 4 CLK, O_SCLK period = 16 CLK, O_LRCK period = 1024 CLK, with 32 SCLK cycles per LRCK level.
REQ-040 Mid-frame reset: assert I_RESET_N=0 during the right slot at p=9 -> O_SDIN, O_SCLK and O_LRCK drop to 0 without waiting for a CLK edge; after release, timing is as in REQ-035.

Source files
------------

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: 16-bit stereo samples in 32-bit slots, MSB one SCLK after
// the LRCK edge, with a free-running codec master clock and a one-cycle
// sample request at each frame capture.
module audio_i2s_tx #(
    parameter int SCLK_HALF   = 8,
    parameter int MCLK_HALF   = 2,
    parameter int UNSIGNED_IN = 1
) (
    input  logic        CLK,
    input  logic        I_RESET_N,
    input  logic [15:0] I_L_DATA,
    input  logic [15:0] I_R_DATA,
    output logic        O_MCLK,
    output logic        O_SCLK,
    output logic        O_LRCK,
    output logic        O_SDIN,
    output logic        O_SAMPLE_REQ
);

    localparam logic [7:0] HC_MAX = 8'(SCLK_HALF - 1);
    localparam logic [7:0] MC_MAX = 8'(MCLK_HALF - 1);

    logic [1:0]  rst_sync;
    logic        run;
    logic [7:0]  hc;
    logic [7:0]  mc;
    logic [5:0]  bc;
    logic [15:0] hl;
    logic [15:0] hr;

    logic        hc_wrap;
    logic        sclk_fall;
    logic [5:0]  bc_new;
    logic [4:0]  slot_pos;
    logic        capture;
    logic [15:0] l_conv;
    logic [15:0] r_conv;
    logic [15:0] word;
    logic [3:0]  bit_idx;
    logic        sdin_next;

    // Reset release synchroniser; assertion clears it immediately.
    always_ff @(posedge CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    // Edge detection, slot position and next serial bit.
    always_comb begin
        hc_wrap   = (hc == HC_MAX);
        sclk_fall = hc_wrap && O_SCLK;
        bc_new    = bc + 6'd1;
        slot_pos  = bc_new[4:0];
        capture   = sclk_fall && (bc_new == '0);
        l_conv    = (UNSIGNED_IN != 0) ? {~I_L_DATA[15], I_L_DATA[14:0]} : I_L_DATA;
        r_conv    = (UNSIGNED_IN != 0) ? {~I_R_DATA[15], I_R_DATA[14:0]} : I_R_DATA;
        word      = bc_new[5] ? hr : hl;
        bit_idx   = 4'(5'd16 - slot_pos);
        sdin_next = 1'b0;
        if ((slot_pos >= 5'd1) && (slot_pos <= 5'd16)) begin
            sdin_next = word[bit_idx];
        end
    end

    // Bit clock, frame counter, serial outputs and sample capture.
    always_ff @(posedge CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            hc           <= '0;
            bc           <= '1;
            hl           <= '0;
            hr           <= '0;
            O_SCLK       <= 1'b0;
            O_LRCK       <= 1'b0;
            O_SDIN       <= 1'b0;
            O_SAMPLE_REQ <= 1'b0;
        end else if (!run) begin
            hc           <= '0;
            bc           <= '1;
            hl           <= '0;
            hr           <= '0;
            O_SCLK       <= 1'b0;
            O_LRCK       <= 1'b0;
            O_SDIN       <= 1'b0;
            O_SAMPLE_REQ <= 1'b0;
        end else begin
            O_SAMPLE_REQ <= capture;
            if (hc_wrap) begin
                hc     <= '0;
                O_SCLK <= ~O_SCLK;
            end else begin
                hc <= hc + 8'd1;
            end
            if (sclk_fall) begin
                bc     <= bc_new;
                O_LRCK <= bc_new[5];
                O_SDIN <= sdin_next;
            end
            if (capture) begin
                hl <= l_conv;
                hr <= r_conv;
            end
        end
    end

    // Codec master clock, free running from reset release.
    always_ff @(posedge CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            mc     <= '0;
            O_MCLK <= 1'b0;
        end else if (!run) begin
            mc     <= '0;
            O_MCLK <= 1'b0;
        end else if (mc == MC_MAX) begin
            mc     <= '0;
            O_MCLK <= ~O_MCLK;
        end else begin
            mc <= mc + 8'd1;
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: a signed-input and an offset-binary instance share
// clock and reset; a time-based reference model is compared every cycle, and
// table vectors plus directed sequences check frames, ratios and reset.
module tb_audio_i2s_tx;

    localparam int SH    = 8;
    localparam int MH    = 2;
    localparam int FRAME = 2 * SH * 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] l_s = '0, r_s = '0, l_u = '0, r_u = '0;
    logic        mclk_s, sclk_s, lrck_s, sdin_s, req_s;
    logic        mclk_u, sclk_u, lrck_u, sdin_u, req_u;

    int n_tests = 0;
    int n_fail  = 0;
    int steps   = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    audio_i2s_tx #(.SCLK_HALF(SH), .MCLK_HALF(MH), .UNSIGNED_IN(0)) dut_s (
        .CLK(clk), .I_RESET_N(rst_n), .I_L_DATA(l_s), .I_R_DATA(r_s),
        .O_MCLK(mclk_s), .O_SCLK(sclk_s), .O_LRCK(lrck_s), .O_SDIN(sdin_s),
        .O_SAMPLE_REQ(req_s)
    );

    audio_i2s_tx #(.SCLK_HALF(SH), .MCLK_HALF(MH), .UNSIGNED_IN(1)) dut_u (
        .CLK(clk), .I_RESET_N(rst_n), .I_L_DATA(l_u), .I_R_DATA(r_u),
        .O_MCLK(mclk_u), .O_SCLK(sclk_u), .O_LRCK(lrck_u), .O_SDIN(sdin_u),
        .O_SAMPLE_REQ(req_u)
    );

    // ---------------- reference model (time based) ----------------
    int unsigned age;
    logic [15:0] m_ls, m_rs, m_lu, m_ru;

    function automatic bit is_capture(int unsigned a);
        int unsigned n;
        n = (a >= 2) ? a - 2 : 0;
        return (n > 0) && (n % (2 * SH) == 0) && (((n / (2 * SH)) - 1) % 64 == 0);
    endfunction

    function automatic logic [4:0] expect_out(int unsigned a, logic [15:0] hl, logic [15:0] hr);
        int unsigned n, f, bcv, p;
        logic mclk, sclk, lrck, sdin;
        logic [15:0] word;
        n    = (a >= 2) ? a - 2 : 0;
        f    = n / (2 * SH);
        mclk = ((n / MH) % 2) == 1;
        sclk = ((n / SH) % 2) == 1;
        lrck = 1'b0;
        sdin = 1'b0;
        if (f >= 1) begin
            bcv  = (f - 1) % 64;
            lrck = (bcv >= 32);
            p    = bcv % 32;
            if (p >= 1 && p <= 16) begin
                word = lrck ? hr : hl;
                sdin = word[16 - p];
            end
        end
        return {mclk, sclk, lrck, sdin, is_capture(a)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age  <= 0;
            m_ls <= '0; m_rs <= '0; m_lu <= '0; m_ru <= '0;
        end else begin
            age <= age + 1;
            if (is_capture(age + 1)) begin
                m_ls <= l_s;
                m_rs <= r_s;
                m_lu <= {~l_u[15], l_u[14:0]};
                m_ru <= {~r_u[15], r_u[14:0]};
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        logic [9:0] act, exp;
        @(negedge clk);
        steps++;
        if (chk_en) begin
            exp = {expect_out(age, m_ls, m_rs), expect_out(age, m_lu, m_ru)};
            act = {mclk_s, sclk_s, lrck_s, sdin_s, req_s, mclk_u, sclk_u, lrck_u, sdin_u, req_u};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL model @%0t: got %b expected %b", $time, act, exp);
            end
        end
    endtask

    task automatic wait_req(output int waited);
        bit ok;
        waited = 0;
        ok = 1'b0;
        while (!ok && waited < FRAME + 100) begin
            step();
            waited++;
            if (req_s) ok = 1'b1;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_timeout: got no pulse expected pulse within %0d cycles", FRAME + 100);
        end
    endtask

    // Samples SDIN/LRCK on the 64 SCLK rising edges following a capture.
    task automatic collect(input int change_k, input logic [15:0] new_l,
                           output logic [63:0] fs, output logic [63:0] fu, output logic [63:0] lr);
        logic prev;
        int   k, budget;
        fs = '0; fu = '0; lr = '0;
        prev = sclk_s;
        k = 0;
        budget = 0;
        while (k < 64 && budget < FRAME + 100) begin
            step();
            budget++;
            if (sclk_s && !prev) begin
                fs[63 - k] = sdin_s;
                fu[63 - k] = sdin_u;
                lr[63 - k] = lrck_s;
                if (k == change_k) l_s = new_l;
                k++;
            end
            prev = sclk_s;
        end
        if (k < 64) begin
            n_tests++;
            n_fail++;
            $display("FAIL collect_timeout: got %0d edges expected 64", k);
        end
    endtask

    function automatic logic [63:0] frame_of(logic [15:0] l, logic [15:0] r);
        return {1'b0, l, 15'b0, 1'b0, r, 15'b0};
    endfunction

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] ls;
        logic [15:0] rs;
        logic [15:0] lu;
        logic [15:0] ru;
    } vec_t;

    localparam logic [63:0] LR_EXP = {32'h0000_0000, 32'hFFFF_FFFF};

    initial begin
        vec_t        vecs[4];
        int          waited, pulses, t1, t2, k, budget;
        logic [63:0] fs, fu, lr;
        logic        prev, pm, ps, pl;
        int          mr0, mr1, sr0, sr1, lr0, lr1, hi_cnt, lo_cnt, hi_lvl, lo_lvl;

        vecs[0] = '{16'hA5C3, 16'h3C5A, 16'hA5C3, 16'h3C5A, 16'h25C3, 16'hBC5A};
        vecs[1] = '{16'h8000, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF};
        vecs[2] = '{16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h8000, 16'h8001};
        vecs[3] = '{16'h7FFF, 16'h8001, 16'h7FFF, 16'h8001, 16'hFFFF, 16'h0001};

        // Reset hold and timed release.
        chk_en = 1'b1;
        rst_n  = 1'b0;
        repeat (10) step();
        chk("reset_outputs", 64'({mclk_s, sclk_s, lrck_s, sdin_s, req_s,
                                  mclk_u, sclk_u, lrck_u, sdin_u, req_u}), 64'd0);
        rst_n = 1'b1;
        wait_req(waited);
        chk("first_req_delay", 64'(waited), 64'd18);
        pulses = 1;
        repeat (1000) begin
            step();
            if (req_s) pulses++;
        end
        chk("req_once", 64'(pulses), 64'd1);

        // Table-driven frame contents.
        for (int i = 0; i < 4; i++) begin
            l_s = vecs[i].l; r_s = vecs[i].r;
            l_u = vecs[i].l; r_u = vecs[i].r;
            wait_req(waited);
            collect(-1, 16'h0, fs, fu, lr);
            chk($sformatf("frame_signed[%0d]", i), fs, frame_of(vecs[i].ls, vecs[i].rs));
            chk($sformatf("frame_offset[%0d]", i), fu, frame_of(vecs[i].lu, vecs[i].ru));
            chk($sformatf("lrck_slots[%0d]", i), lr, LR_EXP);
        end

        // Left input changed mid-slot at p=5.
        l_s = 16'h1234; r_s = 16'h5555;
        wait_req(waited);
        t1 = steps;
        collect(5, 16'hFFFF, fs, fu, lr);
        chk("midchange_current", fs, frame_of(16'h1234, 16'h5555));
        wait_req(waited);
        t2 = steps;
        chk("req_spacing", 64'(t2 - t1), 64'd1024);
        collect(-1, 16'h0, fs, fu, lr);
        chk("midchange_next", fs, frame_of(16'hFFFF, 16'h5555));

        // Clock ratios, with random input activity checked by the model.
        mr0 = -1; mr1 = -1; sr0 = -1; sr1 = -1; lr0 = -1; lr1 = -1;
        hi_cnt = -1; lo_cnt = -1; hi_lvl = -1; lo_lvl = -1;
        pm = mclk_s; ps = sclk_s; pl = lrck_s;
        repeat (2200) begin
            step();
            if ($urandom_range(0, 15) == 0) begin
                l_s = 16'($urandom); r_s = 16'($urandom);
                l_u = 16'($urandom); r_u = 16'($urandom);
            end
            if (mclk_s && !pm) begin
                if (mr0 < 0) mr0 = steps; else if (mr1 < 0) mr1 = steps;
            end
            if (lrck_s && !pl) begin
                if (lr0 < 0) lr0 = steps; else if (lr1 < 0) lr1 = steps;
                if (lo_cnt >= 0 && lo_lvl < 0) lo_lvl = lo_cnt;
                hi_cnt = 0;
            end
            if (!lrck_s && pl) begin
                if (hi_cnt >= 0 && hi_lvl < 0) hi_lvl = hi_cnt;
                lo_cnt = 0;
            end
            if (sclk_s && !ps) begin
                if (sr0 < 0) sr0 = steps; else if (sr1 < 0) sr1 = steps;
                if (lrck_s && hi_cnt >= 0) hi_cnt++;
                if (!lrck_s && lo_cnt >= 0) lo_cnt++;
            end
            pm = mclk_s; ps = sclk_s; pl = lrck_s;
        end
        chk("mclk_period", 64'(mr1 - mr0), 64'd4);
        chk("sclk_period", 64'(sr1 - sr0), 64'd16);
        chk("lrck_period", 64'(lr1 - lr0), 64'd1024);
        chk("sclk_per_lrck_high", 64'(hi_lvl), 64'd32);
        chk("sclk_per_lrck_low", 64'(lo_lvl), 64'd32);

        // Longer randomized run against the model.
        repeat (4 * FRAME) begin
            step();
            if ($urandom_range(0, 31) == 0) begin
                l_s = 16'($urandom); r_s = 16'($urandom);
                l_u = 16'($urandom); r_u = 16'($urandom);
            end
        end

        // Reset asserted in the right slot at p=9.
        wait_req(waited);
        prev = sclk_s;
        k = 0;
        budget = 0;
        while (k < 42 && budget < FRAME) begin
            step();
            budget++;
            if (sclk_s && !prev) k++;
            prev = sclk_s;
        end
        chk("pre_reset_state", 64'({sclk_s, lrck_s, sclk_u, lrck_u}), 64'hF);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 64'({sdin_s, sclk_s, lrck_s, sdin_u, sclk_u, lrck_u}), 64'd0);
        repeat (10) step();
        l_s = 16'hA5C3; r_s = 16'h3C5A;
        l_u = 16'h8000; r_u = 16'hFFFF;
        rst_n = 1'b1;
        wait_req(waited);
        chk("rerelease_req_delay", 64'(waited), 64'd18);
        collect(-1, 16'h0, fs, fu, lr);
        chk("post_reset_frame_signed", fs, frame_of(16'hA5C3, 16'h3C5A));
        chk("post_reset_frame_offset", fu, frame_of(16'h0000, 16'h7FFF));
        chk("post_reset_lrck", lr, LR_EXP);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
